// File: rtl/epd_pkg.sv
// Shared types and constants for the Ethernet frame checker.
// The CRC constants are only consumed when EPD_FCS_CHECK_EN is defined.
package epd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DST,
    ST_SRC,
    ST_TL,
    ST_PAY,
    ST_DROP
  } state_t;

  localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] TL_TYPE_MIN = 16'h0600;
  localparam logic [15:0] TL_LEN_MAX  = 16'd1500;
  localparam logic [10:0] CNT_SAT     = 11'h7FF;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/epd_frame_checker_if.sv
// Byte-stream input and status output bundle of the frame checker.
interface epd_frame_checker_if #(
  parameter int CNT_W = 4
);
  logic [7:0]       data;
  logic             control;
  logic             promisc;
  logic             preamble_valid;
  logic             dst_addr_valid;
  logic             src_addr_valid;
  logic             type_length_valid;
  logic             packet_size_valid;
  logic             packet_done;
  logic [15:0]      type_length;
  logic [CNT_W-1:0] valid_packet_counter;
  logic [CNT_W-1:0] error_packet_counter;
  logic             fcs_ok;

  modport master (
    output data, control, promisc,
    input  preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
           packet_size_valid, packet_done, type_length,
           valid_packet_counter, error_packet_counter, fcs_ok
  );

  modport slave (
    input  data, control, promisc,
    output preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
           packet_size_valid, packet_done, type_length,
           valid_packet_counter, error_packet_counter, fcs_ok
  );
endinterface

// File: rtl/epd_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB-first).
module epd_crc32_byte
  import epd_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] w_stage [9];

  assign w_stage[0] = i_crc ^ {24'd0, i_data};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign w_stage[gi+1] = w_stage[gi][0] ? ((w_stage[gi] >> 1) ^ POLY_REFL)
                                            : (w_stage[gi] >> 1);
    end
  endgenerate

  assign o_crc = w_stage[8];

endmodule

// File: rtl/epd_frame_checker.sv
// Byte-serial Ethernet frame parser/checker with saturating valid/error counters.
// Optional FCS verification is enabled by defining EPD_FCS_CHECK_EN.
module epd_frame_checker
  import epd_pkg::*;
#(
  parameter int          PREAMBLE_LEN  = 8,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [47:0] MY_ADDR       = 48'h010203040506,
  parameter int          MIN_PAYLOAD   = 46,
  parameter int          MAX_PAYLOAD   = 1500,
  parameter int          CNT_W         = 4
) (
  input  logic clock,
  input  logic reset,
  epd_frame_checker_if.slave bus
);

  localparam logic [10:0]      PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0]      MIN_P    = 11'(MIN_PAYLOAD);
  localparam logic [10:0]      MAX_P    = 11'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state, w_state_next;
  logic [10:0]      r_cnt, w_cnt_next;
  logic             r_my_ok, w_my_ok_next;
  logic             r_bc_ok, w_bc_ok_next;
  logic             r_src_uni, w_src_uni_next;
  logic [7:0]       r_tl_hi, w_tl_hi_next;
  logic [15:0]      r_tl, w_tl_next;
  logic             r_pre_v, w_pre_v_next;
  logic             r_dst_v, w_dst_v_next;
  logic             r_src_v, w_src_v_next;
  logic             r_tl_v, w_tl_v_next;
  logic             r_size_v, w_size_v_next;
  logic             r_done, w_done_next;
  logic [CNT_W-1:0] r_vcnt, w_vcnt_next;
  logic [CNT_W-1:0] r_ecnt, w_ecnt_next;

  logic             w_inc_v, w_inc_e;
  logic             w_my_hit, w_bc_hit;
  logic [15:0]      w_tl_cap;
  logic [10:0]      w_pay_cnt;
  logic             w_fcs_eval;
  logic             w_size_eval;

  // Station and broadcast addresses split into bytes, MSB first; slots 6/7 pad the 3-bit index.
  logic [7:0] w_my_bytes [8];
  logic [7:0] w_bc_bytes [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_addr_bytes
      if (gi < 6) begin : g_field
        assign w_my_bytes[gi] = MY_ADDR[47-8*gi -: 8];
        assign w_bc_bytes[gi] = BCAST_ADDR[47-8*gi -: 8];
      end else begin : g_pad
        assign w_my_bytes[gi] = 8'h00;
        assign w_bc_bytes[gi] = 8'h00;
      end
    end
  endgenerate

`ifdef EPD_FCS_CHECK_EN
  logic [31:0] r_crc, w_crc_next, w_crc_byte;
  logic        r_fcs, w_fcs_next;

  epd_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (bus.data),
    .o_crc  (w_crc_byte)
  );

  // The trailing four bytes are the FCS; the reflected register is bit-reversed to match the residue.
  assign w_pay_cnt  = (r_cnt >= 11'd4) ? (r_cnt - 11'd4) : 11'd0;
  assign w_fcs_eval = (r_cnt >= 11'd4) && (reflect32(r_crc) == CRC_RESIDUE);
`else
  assign w_pay_cnt  = r_cnt;
  assign w_fcs_eval = 1'b1;
`endif

  assign w_tl_cap    = {r_tl_hi, bus.data};
  assign w_my_hit    = ((r_cnt == 11'd0) || r_my_ok) && (bus.data == w_my_bytes[r_cnt[2:0]]);
  assign w_bc_hit    = ((r_cnt == 11'd0) || r_bc_ok) && (bus.data == w_bc_bytes[r_cnt[2:0]]);
  assign w_size_eval = (w_pay_cnt >= MIN_P) && (w_pay_cnt <= MAX_P) &&
                       ((r_tl > TL_LEN_MAX) || ({5'd0, w_pay_cnt} == r_tl));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_my_ok_next   = r_my_ok;
    w_bc_ok_next   = r_bc_ok;
    w_src_uni_next = r_src_uni;
    w_tl_hi_next   = r_tl_hi;
    w_tl_next      = r_tl;
    w_pre_v_next   = r_pre_v;
    w_dst_v_next   = r_dst_v;
    w_src_v_next   = r_src_v;
    w_tl_v_next    = r_tl_v;
    w_size_v_next  = r_size_v;
    w_done_next    = 1'b0;
    w_inc_v        = 1'b0;
    w_inc_e        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.control) begin
          w_pre_v_next  = 1'b0;
          w_dst_v_next  = 1'b0;
          w_src_v_next  = 1'b0;
          w_tl_v_next   = 1'b0;
          w_size_v_next = 1'b0;
          w_cnt_next    = 11'd1;
          if (bus.data != PREAMBLE_BYTE) begin
            w_state_next = ST_DROP;
          end else if (PREAMBLE_LEN == 1) begin
            w_pre_v_next = 1'b1;
            w_cnt_next   = 11'd0;
            w_state_next = ST_DST;
          end else begin
            w_state_next = ST_PRE;
          end
        end
      end

      ST_PRE: begin
        if (!bus.control) begin
          w_done_next  = 1'b1;
          w_inc_e      = 1'b1;
          w_state_next = ST_IDLE;
        end else if (bus.data != PREAMBLE_BYTE) begin
          w_state_next = ST_DROP;
        end else if (r_cnt == PRE_LAST) begin
          w_pre_v_next = 1'b1;
          w_cnt_next   = 11'd0;
          w_state_next = ST_DST;
        end else begin
          w_cnt_next = r_cnt + 11'd1;
        end
      end

      ST_DST: begin
        if (!bus.control) begin
          w_done_next  = 1'b1;
          w_inc_e      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_my_ok_next = w_my_hit;
          w_bc_ok_next = w_bc_hit;
          if (r_cnt == 11'd5) begin
            w_dst_v_next = bus.promisc | w_my_hit | w_bc_hit;
            w_cnt_next   = 11'd0;
            w_state_next = ST_SRC;
          end else begin
            w_cnt_next = r_cnt + 11'd1;
          end
        end
      end

      ST_SRC: begin
        if (!bus.control) begin
          w_done_next  = 1'b1;
          w_inc_e      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          if (r_cnt == 11'd0) begin
            w_src_uni_next = ~bus.data[0];
          end
          if (r_cnt == 11'd5) begin
            w_src_v_next = r_src_uni;
            w_cnt_next   = 11'd0;
            w_state_next = ST_TL;
          end else begin
            w_cnt_next = r_cnt + 11'd1;
          end
        end
      end

      ST_TL: begin
        if (!bus.control) begin
          w_done_next  = 1'b1;
          w_inc_e      = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == 11'd0) begin
          w_tl_hi_next = bus.data;
          w_cnt_next   = 11'd1;
        end else begin
          w_tl_next    = w_tl_cap;
          w_tl_v_next  = (w_tl_cap <= TL_LEN_MAX) || (w_tl_cap >= TL_TYPE_MIN);
          w_cnt_next   = 11'd0;
          w_state_next = ST_PAY;
        end
      end

      ST_PAY: begin
        if (bus.control) begin
          w_cnt_next = (r_cnt == CNT_SAT) ? r_cnt : (r_cnt + 11'd1);
        end else begin
          w_size_v_next = w_size_eval;
          w_done_next   = 1'b1;
          w_state_next  = ST_IDLE;
          if (r_pre_v && r_dst_v && r_src_v && r_tl_v && w_size_eval && w_fcs_eval) begin
            w_inc_v = 1'b1;
          end else begin
            w_inc_e = 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (!bus.control) begin
          w_done_next  = 1'b1;
          w_inc_e      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    w_vcnt_next = (w_inc_v && (r_vcnt != CNT_MAX)) ? (r_vcnt + 1'b1) : r_vcnt;
    w_ecnt_next = (w_inc_e && (r_ecnt != CNT_MAX)) ? (r_ecnt + 1'b1) : r_ecnt;

`ifdef EPD_FCS_CHECK_EN
    w_crc_next = r_crc;
    w_fcs_next = r_fcs;
    if (bus.control) begin
      if (r_state == ST_IDLE) begin
        w_crc_next = CRC_INIT;
      end else if (r_state inside {ST_DST, ST_SRC, ST_TL, ST_PAY}) begin
        w_crc_next = w_crc_byte;
      end
    end
    // Runts and dropped frames never reach a complete FCS.
    if (w_done_next) begin
      w_fcs_next = (r_state == ST_PAY) ? w_fcs_eval : 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_my_ok   <= 1'b0;
      r_bc_ok   <= 1'b0;
      r_src_uni <= 1'b0;
      r_tl_hi   <= '0;
      r_tl      <= '0;
      r_pre_v   <= 1'b0;
      r_dst_v   <= 1'b0;
      r_src_v   <= 1'b0;
      r_tl_v    <= 1'b0;
      r_size_v  <= 1'b0;
      r_done    <= 1'b0;
      r_vcnt    <= '0;
      r_ecnt    <= '0;
`ifdef EPD_FCS_CHECK_EN
      r_crc     <= CRC_INIT;
      r_fcs     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_my_ok   <= w_my_ok_next;
      r_bc_ok   <= w_bc_ok_next;
      r_src_uni <= w_src_uni_next;
      r_tl_hi   <= w_tl_hi_next;
      r_tl      <= w_tl_next;
      r_pre_v   <= w_pre_v_next;
      r_dst_v   <= w_dst_v_next;
      r_src_v   <= w_src_v_next;
      r_tl_v    <= w_tl_v_next;
      r_size_v  <= w_size_v_next;
      r_done    <= w_done_next;
      r_vcnt    <= w_vcnt_next;
      r_ecnt    <= w_ecnt_next;
`ifdef EPD_FCS_CHECK_EN
      r_crc     <= w_crc_next;
      r_fcs     <= w_fcs_next;
`endif
    end
  end

  assign bus.preamble_valid       = r_pre_v;
  assign bus.dst_addr_valid       = r_dst_v;
  assign bus.src_addr_valid       = r_src_v;
  assign bus.type_length_valid    = r_tl_v;
  assign bus.packet_size_valid    = r_size_v;
  assign bus.packet_done          = r_done;
  assign bus.type_length          = r_tl;
  assign bus.valid_packet_counter = r_vcnt;
  assign bus.error_packet_counter = r_ecnt;
`ifdef EPD_FCS_CHECK_EN
  assign bus.fcs_ok               = r_fcs;
`else
  assign bus.fcs_ok               = 1'b1;
`endif

endmodule

// File: tb/tb_epd_frame_checker.sv
// Directed bench for epd_frame_checker; appends a real FCS when EPD_FCS_CHECK_EN is defined.
module tb_epd_frame_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  epd_frame_checker_if #(.CNT_W(4)) bus ();

  epd_frame_checker #(.CNT_W(4)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  localparam logic [47:0] MY_ADDR = 48'h010203040506;
  localparam logic [47:0] SRC_OK  = 48'h001122334455;
  localparam logic [47:0] SRC_BAD = 48'hFFFEFDFCFBFA;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;
  logic [7:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] tl,
                       input int plen, input int bad_pre);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back((i == bad_pre) ? 8'h54 : 8'h55);
    for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(src[47-8*i -: 8]);
    q.push_back(tl[15:8]);
    q.push_back(tl[7:0]);
    for (int i = 0; i < plen; i++) q.push_back(8'(i));
  endtask

`ifdef EPD_FCS_CHECK_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic append_fcs(input bit flip);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < q.size(); i++) c = crc_upd(c, q[i]);
    c = ~c;
    if (flip) c[0] = ~c[0];
    for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
  endtask
`endif

  task automatic drive(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      bus.control = 1'b1;
      bus.data    = q[i];
      @(negedge clk);
    end
  endtask

  task automatic end_frame();
    bus.control = 1'b0;
    bus.data    = 8'h00;
    @(negedge clk);
    frame_no++;
    $display("frame %0d: done=%0b pre=%0b dst=%0b src=%0b tl=%0b size=%0b fcs=%0b vcnt=%0d ecnt=%0d",
             frame_no, bus.packet_done, bus.preamble_valid, bus.dst_addr_valid,
             bus.src_addr_valid, bus.type_length_valid, bus.packet_size_valid,
             bus.fcs_ok, bus.valid_packet_counter, bus.error_packet_counter);
  endtask

  task automatic send(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] tl,
                      input int plen, input int bad_pre);
    build(dst, src, tl, plen, bad_pre);
`ifdef EPD_FCS_CHECK_EN
    append_fcs(1'b0);
`endif
    drive(q.size());
    end_frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.control = 1'b0;
    bus.data    = 8'h00;
    bus.promisc = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_pre",   bus.preamble_valid, 0);
    chk("rst_dst",   bus.dst_addr_valid, 0);
    chk("rst_src",   bus.src_addr_valid, 0);
    chk("rst_tlv",   bus.type_length_valid, 0);
    chk("rst_size",  bus.packet_size_valid, 0);
    chk("rst_done",  bus.packet_done, 0);
    chk("rst_tl",    bus.type_length, 0);
    chk("rst_vcnt",  bus.valid_packet_counter, 0);
    chk("rst_ecnt",  bus.error_packet_counter, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    chk("t1_done", bus.packet_done, 1);
    chk("t1_pre",  bus.preamble_valid, 1);
    chk("t1_dst",  bus.dst_addr_valid, 1);
    chk("t1_src",  bus.src_addr_valid, 1);
    chk("t1_tlv",  bus.type_length_valid, 1);
    chk("t1_size", bus.packet_size_valid, 1);
    chk("t1_tl",   bus.type_length, 16'h0800);
    chk("t1_fcs",  bus.fcs_ok, 1);
    chk("t1_vcnt", bus.valid_packet_counter, 1);
    chk("t1_ecnt", bus.error_packet_counter, 0);
    @(negedge clk);
    chk("t1_done_pulse", bus.packet_done, 0);

    send(MY_ADDR, SRC_BAD, 16'h0800, 50, -1);
    chk("t2_src",  bus.src_addr_valid, 0);
    chk("t2_vcnt", bus.valid_packet_counter, 1);
    chk("t2_ecnt", bus.error_packet_counter, 1);

    send(MY_ADDR, SRC_OK, 16'h0030, 50, -1);
    chk("t3_size", bus.packet_size_valid, 0);
    chk("t3_tlv",  bus.type_length_valid, 1);
    chk("t3_tl",   bus.type_length, 16'h0030);
    chk("t3_ecnt", bus.error_packet_counter, 2);

    send(MY_ADDR, SRC_OK, 16'h0032, 50, -1);
    chk("t4_size", bus.packet_size_valid, 1);
    chk("t4_vcnt", bus.valid_packet_counter, 2);

    send(MY_ADDR, SRC_OK, 16'h0800, 40, -1);
    chk("t5_size", bus.packet_size_valid, 0);
    chk("t5_ecnt", bus.error_packet_counter, 3);

    send(MY_ADDR, SRC_OK, 16'h0800, 50, 3);
    chk("t6_done", bus.packet_done, 1);
    chk("t6_pre",  bus.preamble_valid, 0);
    chk("t6_dst",  bus.dst_addr_valid, 0);
    chk("t6_ecnt", bus.error_packet_counter, 4);
    chk("t6_vcnt", bus.valid_packet_counter, 2);

    send(48'hFFFF_FFFF_FFFF, SRC_OK, 16'h0800, 50, -1);
    chk("t7_dst",  bus.dst_addr_valid, 1);
    chk("t7_vcnt", bus.valid_packet_counter, 3);

    send(48'h0A0A_0A0A_0A0A, SRC_OK, 16'h0800, 50, -1);
    chk("t8_dst",  bus.dst_addr_valid, 0);
    chk("t8_ecnt", bus.error_packet_counter, 5);

    bus.promisc = 1'b1;
    send(48'h0A0A_0A0A_0A0A, SRC_OK, 16'h0800, 50, -1);
    chk("t9_dst",  bus.dst_addr_valid, 1);
    chk("t9_vcnt", bus.valid_packet_counter, 4);
    bus.promisc = 1'b0;

    build(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    drive(11);
    end_frame();
    chk("t10_done", bus.packet_done, 1);
    chk("t10_pre",  bus.preamble_valid, 1);
    chk("t10_dst",  bus.dst_addr_valid, 0);
    chk("t10_ecnt", bus.error_packet_counter, 6);
    chk("t10_vcnt", bus.valid_packet_counter, 4);

    send(MY_ADDR, SRC_OK, 16'h05FF, 50, -1);
    chk("t11_tlv",  bus.type_length_valid, 0);
    chk("t11_size", bus.packet_size_valid, 1);
    chk("t11_ecnt", bus.error_packet_counter, 7);

    send(MY_ADDR, SRC_OK, 16'h0600, 50, -1);
    chk("t12_tlv",  bus.type_length_valid, 1);
    chk("t12_vcnt", bus.valid_packet_counter, 5);

    send(MY_ADDR, SRC_OK, 16'h05DC, 50, -1);
    chk("t13_tlv",  bus.type_length_valid, 1);
    chk("t13_size", bus.packet_size_valid, 0);
    chk("t13_ecnt", bus.error_packet_counter, 8);

    for (int k = 0; k < 16; k++) send(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    chk("sat_done", bus.packet_done, 1);
    chk("sat_vcnt", bus.valid_packet_counter, 15);
    chk("sat_ecnt", bus.error_packet_counter, 8);

    build(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    drive(30);
    rst_n = 1'b0;
    #1;
    chk("mrst_pre",  bus.preamble_valid, 0);
    chk("mrst_dst",  bus.dst_addr_valid, 0);
    chk("mrst_src",  bus.src_addr_valid, 0);
    chk("mrst_tlv",  bus.type_length_valid, 0);
    chk("mrst_tl",   bus.type_length, 0);
    chk("mrst_vcnt", bus.valid_packet_counter, 0);
    chk("mrst_ecnt", bus.error_packet_counter, 0);
    bus.control = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle_done", bus.packet_done, 0);

    send(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    chk("post_rst_vcnt", bus.valid_packet_counter, 1);
    chk("post_rst_ecnt", bus.error_packet_counter, 0);
    chk("post_rst_fcs",  bus.fcs_ok, 1);

`ifdef EPD_FCS_CHECK_EN
    build(MY_ADDR, SRC_OK, 16'h0800, 50, -1);
    append_fcs(1'b1);
    drive(q.size());
    end_frame();
    chk("fcs_bad_ok",   bus.fcs_ok, 0);
    chk("fcs_bad_size", bus.packet_size_valid, 1);
    chk("fcs_bad_ecnt", bus.error_packet_counter, 1);
    chk("fcs_bad_vcnt", bus.valid_packet_counter, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
